// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared state encodings, ASCII constants and the echo
//                transform for the recv_send responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_GUARD = 2'd1,
        T_BUSY  = 2'd2
    } tx_state_t;

    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    // Lower-case letters are folded to upper case only when 'upper' is set.
    function automatic logic [7:0] echo_xform(input logic [7:0] b, input logic upper);
        if (upper && (b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
            return b - ASCII_CASE_OFS;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/recv_send_if.sv
`default_nettype none
// ============================================================================
//  Module      : recv_send_if
//  Description : Byte handshake bundle between the responder and the
//                RX/TX UART pair.
//  Revision    : 1.0 - initial release
// ============================================================================
interface recv_send_if;

    logic [7:0] in_rx_data;
    logic       in_rx_valid;
    logic       out_rd_strobe;
    logic [7:0] out_tx_data;
    logic       out_wr_strobe;
    logic       in_tx_busy;

    // Responder side.
    modport master (
        input  in_rx_data,
        input  in_rx_valid,
        input  in_tx_busy,
        output out_rd_strobe,
        output out_tx_data,
        output out_wr_strobe
    );

    // UART side.
    modport slave (
        output in_rx_data,
        output in_rx_valid,
        output in_tx_busy,
        input  out_rd_strobe,
        input  out_tx_data,
        input  out_wr_strobe
    );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Power-of-two synchronous FIFO with registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          push,
    input  wire logic                          pop,
    input  wire logic [WIDTH-1:0]              wdata,
    output logic      [WIDTH-1:0]              rdata,
    output logic                               full,
    output logic                               empty,
    output logic      [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rdata_q;

    logic w_push;
    logic w_pop;

    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = rdata_q;
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rdata_q <= mem_q[rptr_q];
                rptr_q  <= rptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/recv_send.sv
`default_nettype none
// ============================================================================
//  Module      : recv_send
//  Description : UART echo responder - acks RX bytes, buffers them and
//                returns them (optionally upper-cased) through the TX UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module recv_send
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit UPPERCASE  = 1'b0,
    parameter int CNT_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             in_echo_en,
    output logic      [7:0]       out_rx_data,
    output logic                  out_rx_strobe,
    output logic      [CNT_W-1:0] out_rx_count,
    output logic      [CNT_W-1:0] out_tx_count,
    output logic                  out_fifo_full,
    recv_send_if.master           uart
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_state_t rx_state_q, rx_state_d;
    tx_state_t tx_state_q, tx_state_d;

    logic [7:0]       rx_data_q;
    logic             rx_strobe_q;
    logic             rd_strobe_q;
    logic             wr_strobe_q;
    logic [CNT_W-1:0] rx_count_q;
    logic [CNT_W-1:0] tx_count_q;

    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [AW:0]      w_fifo_count;
    logic [7:0]       w_fifo_rdata;
    logic [7:0]       w_echo_byte;

    assign w_echo_byte = echo_xform(uart.in_rx_data, UPPERCASE);

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_echo_byte),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // The stall decision uses the pre-pop full flag, so a same-cycle pop
    // never frees space for the push; RX simply waits one more cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        w_ack      = 1'b0;
        w_push     = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (uart.in_rx_valid && (!in_echo_en || !w_fifo_full)) begin
                    w_ack      = 1'b1;
                    w_push     = in_echo_en;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK:   rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        w_pop      = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!w_fifo_empty && !uart.in_tx_busy) begin
                    w_pop      = 1'b1;
                    tx_state_d = T_GUARD;
                end
            end
            T_GUARD: tx_state_d = T_BUSY;
            T_BUSY: begin
                if (!uart.in_tx_busy) begin
                    tx_state_d = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q  <= R_IDLE;
            tx_state_q  <= T_IDLE;
            rx_data_q   <= '0;
            rx_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            rx_count_q  <= '0;
            tx_count_q  <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            rd_strobe_q <= w_ack;
            rx_strobe_q <= w_ack;
            wr_strobe_q <= w_pop;
            if (w_ack) begin
                rx_data_q  <= uart.in_rx_data;
                rx_count_q <= rx_count_q + CNT_W'(1);
            end
            if (w_pop) begin
                tx_count_q <= tx_count_q + CNT_W'(1);
            end
        end
    end

    assign out_rx_data        = rx_data_q;
    assign out_rx_strobe      = rx_strobe_q;
    assign out_rx_count       = rx_count_q;
    assign out_tx_count       = tx_count_q;
    assign out_fifo_full      = (w_fifo_count == (AW+1)'(FIFO_DEPTH));
    assign uart.out_rd_strobe = rd_strobe_q;
    assign uart.out_wr_strobe = wr_strobe_q;
    assign uart.out_tx_data   = w_fifo_rdata;

endmodule
`default_nettype wire

// File: tb/tb_recv_send.sv
`default_nettype none
// ============================================================================
//  Module      : tb_recv_send
//  Description : Self-checking bench for recv_send with RX/TX UART models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_recv_send;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             echo = 1'b1;
    logic [7:0]       rx_data;
    logic             rx_strobe;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic             fifo_full;

    recv_send_if uart ();

    recv_send #(
        .FIFO_DEPTH (4),
        .UPPERCASE  (1'b1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_echo_en    (echo),
        .out_rx_data   (rx_data),
        .out_rx_strobe (rx_strobe),
        .out_rx_count  (rx_count),
        .out_tx_count  (tx_count),
        .out_fifo_full (fifo_full),
        .uart          (uart)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_src[$];
    logic [7:0] obs_rx[$];
    logic [7:0] obs_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int  n_ack, rd_run, rd_run_max, busy_cnt, cyc, ack_cyc, wr_cyc;
    int  tx_hold = 2;
    bit  hold_busy = 1'b0;
    int  sw_rx, sw_tx;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  ok;

    // Monitor plus RX/TX UART behavioural models.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            rx_src.delete();
            obs_rx.delete();
            obs_tx.delete();
            n_ack = 0; rd_run = 0; rd_run_max = 0; busy_cnt = 0;
        end else begin
            if (uart.out_rd_strobe) begin
                n_ack++;
                ack_cyc = cyc;
                rd_run++;
            end else begin
                rd_run = 0;
            end
            if (rd_run > rd_run_max) rd_run_max = rd_run;
            if (rx_strobe) obs_rx.push_back(rx_data);
            if (uart.out_wr_strobe) begin
                obs_tx.push_back(uart.out_tx_data);
                wr_cyc = cyc;
            end
            if (uart.out_rd_strobe && rx_src.size() > 0) void'(rx_src.pop_front());
            if (uart.out_wr_strobe) busy_cnt = tx_hold;
            else if (busy_cnt > 0) busy_cnt--;
        end
        uart.in_rx_valid = (rx_src.size() > 0);
        uart.in_rx_data  = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
        uart.in_tx_busy  = hold_busy || (busy_cnt > 0);
    end

    function automatic logic [7:0] ref_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7a) ? (b - 8'h20) : b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        exp_rx.delete();
        exp_tx.delete();
        sw_rx = 0;
        sw_tx = 0;
        cycles(2);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_src.push_back(b);
        exp_rx.push_back(b);
        sw_rx++;
        if (echo) begin
            exp_tx.push_back(ref_upper(b));
            sw_tx++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        cycles(2);
        n_checks++;
        if (rx_count !== 4'd0 || tx_count !== 4'd0) $display("FAIL reset_counts: got rx=%0d tx=%0d expected 0/0", rx_count, tx_count);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h00 || uart.out_tx_data !== 8'h00) $display("FAIL reset_data: got rx=%h tx=%h expected 00/00", rx_data, uart.out_tx_data);
        else n_pass++;
        n_checks++;
        if ({rx_strobe, uart.out_rd_strobe, uart.out_wr_strobe, fifo_full} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {rx_strobe, uart.out_rd_strobe, uart.out_wr_strobe, fifo_full});
        else n_pass++;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        echo = 1'b1; tx_hold = 10;
        send(8'h41);
        cycles(25);
        n_checks++;
        if (n_ack !== 1 || rd_run_max !== 1) $display("FAIL single_ack: got acks=%0d width=%0d expected 1/1", n_ack, rd_run_max);
        else n_pass++;
        n_checks++;
        if (obs_rx.size() != 1 || obs_rx[0] !== exp_rx[0]) $display("FAIL single_rx: got n=%0d expected 1 byte %h", obs_rx.size(), exp_rx[0]);
        else n_pass++;
        n_checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== exp_tx[0]) $display("FAIL single_tx: got n=%0d expected 1 byte %h", obs_tx.size(), exp_tx[0]);
        else n_pass++;
        n_checks++;
        if (wr_cyc - ack_cyc < 1 || wr_cyc - ack_cyc > 3) $display("FAIL single_latency: got %0d cycles expected 1..3", wr_cyc - ack_cyc);
        else n_pass++;
        n_checks++;
        if (rx_count !== CNT_W'(sw_rx) || tx_count !== CNT_W'(sw_tx)) $display("FAIL single_counts: got rx=%0d tx=%0d expected %0d/%0d", rx_count, tx_count, sw_rx, sw_tx);
        else n_pass++;
    endtask

    task automatic test_uppercase();
        do_reset();
        echo = 1'b1; tx_hold = 2;
        send(8'h61); send(8'h7a); send(8'h7b); send(8'h30);
        cycles(60);
        n_checks++;
        ok = (obs_rx.size() == exp_rx.size());
        if (!ok) $display("FAIL upper_rx size: got %0d expected %0d", obs_rx.size(), exp_rx.size());
        for (int i = 0; ok && i < exp_rx.size(); i++)
            if (obs_rx[i] !== exp_rx[i]) begin ok = 0; $display("FAIL upper_rx[%0d]: got %h expected %h", i, obs_rx[i], exp_rx[i]); end
        if (ok) n_pass++;
        n_checks++;
        ok = (obs_tx.size() == exp_tx.size());
        if (!ok) $display("FAIL upper_tx size: got %0d expected %0d", obs_tx.size(), exp_tx.size());
        for (int i = 0; ok && i < exp_tx.size(); i++)
            if (obs_tx[i] !== exp_tx[i]) begin ok = 0; $display("FAIL upper_tx[%0d]: got %h expected %h", i, obs_tx[i], exp_tx[i]); end
        if (ok) n_pass++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        echo = 1'b1; tx_hold = 2; hold_busy = 1'b1;
        for (int i = 1; i <= 6; i++) send(8'(i));
        cycles(30);
        n_checks++;
        if (n_ack !== 4 || fifo_full !== 1'b1) $display("FAIL full_stall: got acks=%0d full=%b expected 4/1", n_ack, fifo_full);
        else n_pass++;
        hold_busy = 1'b0;
        cycles(80);
        n_checks++;
        ok = (obs_tx.size() == exp_tx.size());
        if (!ok) $display("FAIL full_tx size: got %0d expected %0d", obs_tx.size(), exp_tx.size());
        for (int i = 0; ok && i < exp_tx.size(); i++)
            if (obs_tx[i] !== exp_tx[i]) begin ok = 0; $display("FAIL full_tx[%0d]: got %h expected %h", i, obs_tx[i], exp_tx[i]); end
        if (ok) n_pass++;
        n_checks++;
        if (rx_count !== CNT_W'(sw_rx) || tx_count !== CNT_W'(sw_tx) || fifo_full !== 1'b0)
            $display("FAIL full_counts: got rx=%0d tx=%0d full=%b expected %0d/%0d/0", rx_count, tx_count, fifo_full, sw_rx, sw_tx);
        else n_pass++;
    endtask

    task automatic test_echo_off();
        do_reset();
        echo = 1'b0; tx_hold = 2;
        send(8'h61); send(8'h62); send(8'h63);
        cycles(30);
        n_checks++;
        if (n_ack !== 3 || obs_rx.size() != 3) $display("FAIL echo_off_acks: got acks=%0d rx=%0d expected 3/3", n_ack, obs_rx.size());
        else n_pass++;
        n_checks++;
        if (obs_rx.size() == 3 && obs_rx[2] !== exp_rx[2]) $display("FAIL echo_off_raw: got %h expected %h", obs_rx[2], exp_rx[2]);
        else n_pass++;
        n_checks++;
        if (obs_tx.size() != 0 || tx_count !== 4'd0 || rx_count !== CNT_W'(sw_rx))
            $display("FAIL echo_off_tx: got wr=%0d tx=%0d rx=%0d expected 0/0/%0d", obs_tx.size(), tx_count, rx_count, sw_rx);
        else n_pass++;
        echo = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        echo = 1'b1; tx_hold = 2; hold_busy = 1'b1;
        send(8'h11); send(8'h22);
        cycles(10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (rx_count !== 4'd0 || rx_data !== 8'h00 || rx_strobe !== 1'b0)
            $display("FAIL reset_mid_async: got cnt=%0d data=%h strobe=%b expected 0/00/0", rx_count, rx_data, rx_strobe);
        else n_pass++;
        exp_rx.delete(); exp_tx.delete(); sw_rx = 0; sw_tx = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        hold_busy = 1'b0;
        cycles(20);
        n_checks++;
        if (obs_tx.size() != 0 || tx_count !== 4'd0) $display("FAIL reset_mid_flush: got wr=%0d tx=%0d expected 0/0", obs_tx.size(), tx_count);
        else n_pass++;
        send(8'h55);
        cycles(20);
        n_checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== 8'h55 || tx_count !== 4'd1)
            $display("FAIL reset_mid_new: got wr=%0d tx=%0d expected 1 byte 55/1", obs_tx.size(), tx_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        echo = 1'b1; tx_hold = 1;
        for (int i = 0; i < 17; i++) send(8'h80 + 8'(i));
        cycles(17 * 8 + 20);
        n_checks++;
        if (rx_count !== CNT_W'(sw_rx) || tx_count !== CNT_W'(sw_tx) || rx_count !== 4'd1)
            $display("FAIL wrap_counts: got rx=%0d tx=%0d expected 1/1", rx_count, tx_count);
        else n_pass++;
        n_checks++;
        ok = (obs_tx.size() == exp_tx.size());
        if (!ok) $display("FAIL wrap_tx size: got %0d expected %0d", obs_tx.size(), exp_tx.size());
        for (int i = 0; ok && i < exp_tx.size(); i++)
            if (obs_tx[i] !== exp_tx[i]) begin ok = 0; $display("FAIL wrap_tx[%0d]: got %h expected %h", i, obs_tx[i], exp_tx[i]); end
        if (ok) n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_uppercase();
        test_fifo_full();
        test_echo_off();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/recv_send.md
Name: recv_send

Overview:
- UART-side responder: waits for a received byte, acknowledges it to the RX UART, and returns an echo byte through the TX UART.
- Responder/echo end of the send-then-wait-for-reply exchange used by the serial_fpga test path.
- A small byte FIFO decouples RX from TX, so back-to-back received bytes are not lost while TX is busy.
- Also exposes each received byte to user logic, plus RX/TX byte counters.

Parameters:
FIFO_DEPTH, 4, echo buffer entries; power of 2, minimum 2
UPPERCASE, 0, 1 = map echoed bytes 0x61..0x7A ('a'..'z') to byte-0x20; all other bytes unchanged
CNT_W, 16, width of the RX/TX byte counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset; one clock domain only
in_echo_en  in  1  1 = echo received bytes; 0 = deliver to user only, never push
out_rx_data  out  8  last received byte (raw, untransformed)
out_rx_strobe  out  1  one-cycle pulse when out_rx_data updates
out_rx_count  out  CNT_W  bytes acknowledged from RX UART, wraps to 0
out_tx_count  out  CNT_W  bytes written to TX UART, wraps to 0
out_fifo_full  out  1  echo FIFO full (RX is stalling)
in_rx_data  in  8  RX UART byte
in_rx_valid  in  1  RX UART holds an unread byte; level signal
out_rd_strobe  out  1  one-cycle ack to RX UART; clears in_rx_valid at most 1 cycle later
out_tx_data  out  8  byte to TX UART
out_wr_strobe  out  1  one-cycle write pulse to TX UART
in_tx_busy  in  1  TX UART shifting; rises at most 1 cycle after out_wr_strobe

Behaviour:
Reset (async assert, sync use at next edge after deassert):
- All outputs 0; both FSMs return to idle; FIFO emptied; counters 0.
- Reset mid-transfer drops any buffered bytes; no strobe is issued in the cycle after release.

RX FSM: R_IDLE, R_ACK.
- R_IDLE, in_rx_valid=1 and (in_echo_en=0 or FIFO not full):
  - out_rd_strobe=1 for one cycle.
  - Capture in_rx_data into out_rx_data; pulse out_rx_strobe.
  - Increment out_rx_count.
  - If in_echo_en=1, push the byte, transformed per UPPERCASE.
  - Go to R_ACK.
- R_IDLE, in_rx_valid=1 and echo enabled and FIFO full: stall. No ack; byte stays in the RX UART. Never drop, never overwrite.
- R_ACK: one guard cycle so in_rx_valid can fall; return to R_IDLE unconditionally.
- Minimum RX spacing is therefore 2 cycles per byte.

TX FSM: T_IDLE, T_GUARD, T_BUSY.
- T_IDLE, FIFO not empty and in_tx_busy=0:
  - Pop the FIFO head into out_tx_data.
  - out_wr_strobe=1 for one cycle.
  - Increment out_tx_count.
  - Go to T_GUARD.
- T_GUARD: one cycle, ignores in_tx_busy; go to T_BUSY.
- T_BUSY: wait for in_tx_busy=0, then T_IDLE.
- Minimum TX spacing is therefore 3 cycles per byte.
- out_tx_data holds its value until the next pop.

FIFO:
- Push (RX side) and pop (TX side) in the same cycle are legal in any occupancy state.
- Pop when empty never occurs. When full, a simultaneous pop does not unblock the push in that cycle; RX stalls one extra cycle.
- Registered read data, first-word latency 1 cycle. TX strobe is therefore issued in the cycle after the FIFO becomes non-empty.
- out_fifo_full is combinational from the occupancy count.

Echo enable:
- in_echo_en is sampled only at the R_IDLE ack decision.
- Toggling it does not flush bytes already buffered; those are still transmitted.

Counters: modulo 2^CNT_W, no saturation.

Byte ordering: TX order equals RX ack order.

Decomposition:
- Package serial_pkg holds:
  - FSM state localparams: R_IDLE=0, R_ACK=1, T_IDLE=0, T_GUARD=1, T_BUSY=2.
  - Constants ASCII_LC_A=8'h61, ASCII_LC_Z=8'h7A, ASCII_CASE_OFS=8'h20.
- Sub-module byte_fifo holds the FIFO storage:
  - Parameters FIFO_DEPTH and width 8.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Async reset.
- recv_send holds both FSMs, the transform and the counters.

Test Plan:
- Single byte, UPPERCASE=0, echo on:
  - Stimulus: in_rx_valid with 0x41; TX model raises busy the cycle after strobe and holds it 10 cycles.
  - Required: out_rd_strobe 1 cycle; out_rx_strobe with out_rx_data=0x41; out_wr_strobe with out_tx_data=0x41 within 3 cycles of ack; both counts = 1.
- UPPERCASE=1:
  - Stimulus: receive 0x61, 0x7A, 0x7B, 0x30.
  - Required: TX sequence 0x41, 0x5A, 0x7B, 0x30; out_rx_data shows the raw bytes.
- FIFO full, FIFO_DEPTH=4:
  - Stimulus: hold in_tx_busy=1; offer 6 bytes 0x01..0x06.
  - Required: 4 acks then out_fifo_full=1 and no 5th ack. After busy drops, TX emits 0x01..0x06 in order; rx_count = tx_count = 6; no loss.
- Echo disabled:
  - Stimulus: in_echo_en=0; receive 3 bytes.
  - Required: 3 acks; out_rx_strobe ×3; out_wr_strobe never asserted; tx_count=0.
- Reset mid-operation:
  - Stimulus: 2 bytes buffered while TX is busy; pulse reset asynchronously between clock edges.
  - Required: outputs go to 0 immediately; FIFO empty; no wr_strobe after release until a new byte is received.
- Counter wrap, CNT_W=4:
  - Stimulus: receive 17 bytes.
  - Required: out_rx_count=1; out_tx_count=1 after all bytes are echoed.
